// File: rtl/alu_cnt_dec_pkg.sv
// Shared constants for the lab-board ALU / down-counter / decoder cluster:
// ALU operation encodings and default widths.
package alu_cnt_dec_pkg;

  localparam int unsigned ALU_W = 4;
  localparam int unsigned CNT_W = 3;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_NOT = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_LT  = 3'b110;
  localparam logic [2:0] ALU_EQ  = 3'b111;

endpackage

// File: rtl/alu_cnt_dec_unit_alu_core.sv
// Combinational ALU: eight operations plus zero / signed-overflow / carry flags.
// Carry and overflow are only meaningful for ADD and SUB; all other ops force them low.
module alu_core #(
  parameter int unsigned ALU_W = alu_cnt_dec_pkg::ALU_W
) (
  input  logic [2:0]       i_sel,
  input  logic [ALU_W-1:0] i_a,
  input  logic [ALU_W-1:0] i_b,
  output logic [ALU_W-1:0] o_res,
  output logic             o_zero,
  output logic             o_overflow,
  output logic             o_carry
);
  import alu_cnt_dec_pkg::*;

  localparam int unsigned M = ALU_W - 1;

  logic [ALU_W:0] w_add;
  logic [ALU_W:0] w_sub;
  logic           w_add_ovf;
  logic           w_sub_ovf;
  logic           w_less;

  assign w_add     = {1'b0, i_a} + {1'b0, i_b};
  assign w_sub     = {1'b0, i_a} + {1'b0, ~i_b} + {{ALU_W{1'b0}}, 1'b1};
  assign w_add_ovf = (i_a[M] == i_b[M]) && (w_add[M] != i_a[M]);
  assign w_sub_ovf = (i_a[M] != i_b[M]) && (w_sub[M] != i_a[M]);
  // Signed less-than taken from the subtractor sign corrected by its overflow
  assign w_less    = w_sub[M] ^ w_sub_ovf;

  always_comb begin
    o_res      = '0;
    o_carry    = 1'b0;
    o_overflow = 1'b0;
    case (i_sel)
      ALU_ADD: begin
        o_res      = w_add[M:0];
        o_carry    = w_add[ALU_W];
        o_overflow = w_add_ovf;
      end
      ALU_SUB: begin
        o_res      = w_sub[M:0];
        o_carry    = w_sub[ALU_W];
        o_overflow = w_sub_ovf;
      end
      ALU_NOT: o_res = ~i_a;
      ALU_AND: o_res = i_a & i_b;
      ALU_OR:  o_res = i_a | i_b;
      ALU_XOR: o_res = i_a ^ i_b;
      ALU_LT:  o_res = {{(ALU_W-1){1'b0}}, w_less};
      ALU_EQ:  o_res = {{(ALU_W-1){1'b0}}, (i_a == i_b)};
      default: o_res = '0;
    endcase
  end

  assign o_zero = (o_res == '0);

endmodule

// File: rtl/alu_cnt_dec_unit.sv
// Lab-board cluster: ALU, wrapping down-counter and 3-to-8 one-hot decoder.
// Define ALU_OUT_REG_EN to register the ALU outputs (1-cycle latency, cleared by rst).
module alu_cnt_dec_unit #(
  parameter int unsigned ALU_W = alu_cnt_dec_pkg::ALU_W,
  parameter int unsigned CNT_W = alu_cnt_dec_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       alu_fnselec,
  input  logic [ALU_W-1:0] alu_a,
  input  logic [ALU_W-1:0] alu_b,
  output logic [ALU_W-1:0] alu_res,
  output logic             alu_zero,
  output logic             alu_overflow,
  output logic             alu_carry,
  input  logic             cnt_en,
  output logic [CNT_W-1:0] cnt_q,
  output logic             cnt_tc,
  input  logic             dec_en,
  input  logic [2:0]       dec_x,
  output logic [7:0]       dec_y
);
  import alu_cnt_dec_pkg::*;

  logic [ALU_W-1:0] w_res;
  logic             w_zero;
  logic             w_overflow;
  logic             w_carry;

  alu_core #(.ALU_W(ALU_W)) u_alu_core (
    .i_sel      (alu_fnselec),
    .i_a        (alu_a),
    .i_b        (alu_b),
    .o_res      (w_res),
    .o_zero     (w_zero),
    .o_overflow (w_overflow),
    .o_carry    (w_carry)
  );

`ifdef ALU_OUT_REG_EN
  logic [ALU_W-1:0] r_alu_res;
  logic             r_alu_zero;
  logic             r_alu_overflow;
  logic             r_alu_carry;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_res      <= '0;
      r_alu_zero     <= 1'b0;
      r_alu_overflow <= 1'b0;
      r_alu_carry    <= 1'b0;
    end else begin
      r_alu_res      <= w_res;
      r_alu_zero     <= w_zero;
      r_alu_overflow <= w_overflow;
      r_alu_carry    <= w_carry;
    end
  end

  assign alu_res      = r_alu_res;
  assign alu_zero     = r_alu_zero;
  assign alu_overflow = r_alu_overflow;
  assign alu_carry    = r_alu_carry;
`else
  assign alu_res      = w_res;
  assign alu_zero     = w_zero;
  assign alu_overflow = w_overflow;
  assign alu_carry    = w_carry;
`endif

  logic [CNT_W-1:0] r_cnt;

  // Reset takes priority over enable; decrement wraps 0 -> all ones naturally
  always_ff @(posedge clk) begin
    if (rst)         r_cnt <= '0;
    else if (cnt_en) r_cnt <= r_cnt - CNT_W'(1);
  end

  assign cnt_q  = r_cnt;
  assign cnt_tc = (r_cnt == '0);

  assign dec_y = dec_en ? (8'b1 << dec_x) : 8'b0;

endmodule

// File: tb/tb_alu_cnt_dec_unit.sv
// Self-checking bench for alu_cnt_dec_unit using an expected-value queue.
// Handles both builds; ALU_OUT_REG_EN adds one cycle before ALU results are checked.
module tb_alu_cnt_dec_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] alu_fnselec;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_res;
  logic       alu_zero;
  logic       alu_overflow;
  logic       alu_carry;
  logic       cnt_en;
  logic [2:0] cnt_q;
  logic       cnt_tc;
  logic       dec_en;
  logic [2:0] dec_x;
  logic [7:0] dec_y;

  always #5 clk = ~clk;

  alu_cnt_dec_unit #(.ALU_W(4), .CNT_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_fnselec  (alu_fnselec),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_res      (alu_res),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .alu_carry    (alu_carry),
    .cnt_en       (cnt_en),
    .cnt_q        (cnt_q),
    .cnt_tc       (cnt_tc),
    .dec_en       (dec_en),
    .dec_x        (dec_x),
    .dec_y        (dec_y)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fails  = 0;
  logic [6:0]  last_alu_exp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] got);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", got, 32'hDEAD_BEEF);
    end else begin
      e = sb.pop_front();
      check(e.tag, got, e.exp);
    end
  endtask

  function automatic int sgn4(input logic [3:0] v);
    return v[3] ? int'(v) - 16 : int'(v);
  endfunction

  // Reference ALU in integer arithmetic; packs {res, zero, overflow, carry}
  function automatic logic [6:0] alu_model(input logic [2:0] s, input logic [3:0] a,
                                           input logic [3:0] b);
    int         u, sv;
    logic [3:0] r;
    logic       c, o;
    r = 4'h0; c = 1'b0; o = 1'b0;
    case (s)
      3'd0: begin
        u = int'(a) + int'(b); sv = sgn4(a) + sgn4(b);
        r = u[3:0]; c = (u > 15); o = (sv > 7) || (sv < -8);
      end
      3'd1: begin
        u = int'(a) - int'(b); sv = sgn4(a) - sgn4(b);
        r = u[3:0]; c = (a >= b); o = (sv > 7) || (sv < -8);
      end
      3'd2: r = ~a;
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      3'd6: r = (sgn4(a) < sgn4(b)) ? 4'h1 : 4'h0;
      default: r = (a == b) ? 4'h1 : 4'h0;
    endcase
    return {r, (r == 4'h0), o, c};
  endfunction

  task automatic alu_apply(input string tag, input logic [2:0] s, input logic [3:0] a,
                           input logic [3:0] b, input logic [6:0] e);
    @(negedge clk);
    alu_fnselec = s; alu_a = a; alu_b = b;
    push_exp(tag, 32'(e));
`ifdef ALU_OUT_REG_EN
    @(posedge clk); #1;
`else
    #1;
`endif
    pop_check(32'({alu_res, alu_zero, alu_overflow, alu_carry}));
    last_alu_exp = e;
  endtask

  task automatic cnt_step(input string tag, input logic r, input logic en,
                          input logic [2:0] e);
    @(negedge clk);
    rst = r; cnt_en = en;
    push_exp(tag, 32'({(e == 3'd0), e}));
    @(posedge clk); #1;
    pop_check(32'({cnt_tc, cnt_q}));
  endtask

  int exp_cnt[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};

  initial begin
    rst = 1'b1; cnt_en = 1'b0; alu_fnselec = 3'd0; alu_a = 4'h0; alu_b = 4'h0;
    dec_en = 1'b0; dec_x = 3'd0;
    last_alu_exp = 7'h0;

    // Reset state of the counter
    repeat (2) @(posedge clk);
    #1;
    check("rst_cnt_q", 32'(cnt_q), 32'd0);
    check("rst_cnt_tc", 32'(cnt_tc), 32'd1);
`ifdef ALU_OUT_REG_EN
    check("rst_alu_outs", 32'({alu_res, alu_zero, alu_overflow, alu_carry}), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Directed ALU vectors with hand-derived {res,zero,ovf,carry}
    alu_apply("add_ovf",   3'b000, 4'b0111, 4'b0001, {4'b1000, 1'b0, 1'b1, 1'b0});
    alu_apply("add_carry", 3'b000, 4'b1111, 4'b0001, {4'b0000, 1'b1, 1'b0, 1'b1});
    alu_apply("sub_ovf",   3'b001, 4'b1000, 4'b0001, {4'b0111, 1'b0, 1'b1, 1'b1});
    alu_apply("sub_zero",  3'b001, 4'b0000, 4'b0000, {4'b0000, 1'b1, 1'b0, 1'b1});
    alu_apply("sub_borrow",3'b001, 4'b0000, 4'b0001, {4'b1111, 1'b0, 1'b0, 1'b0});
    alu_apply("lt_neg",    3'b110, 4'b1000, 4'b0001, {4'b0001, 1'b0, 1'b0, 1'b0});
    alu_apply("lt_pos",    3'b110, 4'b0011, 4'b1111, {4'b0000, 1'b1, 1'b0, 1'b0});
    alu_apply("not",       3'b010, 4'b1010, 4'b0110, {4'b0101, 1'b0, 1'b0, 1'b0});
    alu_apply("and",       3'b011, 4'b1010, 4'b0110, {4'b0010, 1'b0, 1'b0, 1'b0});
    alu_apply("or",        3'b100, 4'b1010, 4'b0110, {4'b1110, 1'b0, 1'b0, 1'b0});
    alu_apply("xor",       3'b101, 4'b1010, 4'b0110, {4'b1100, 1'b0, 1'b0, 1'b0});
    alu_apply("eq_true",   3'b111, 4'b0101, 4'b0101, {4'b0001, 1'b0, 1'b0, 1'b0});
    alu_apply("eq_false",  3'b111, 4'b0101, 4'b0100, {4'b0000, 1'b1, 1'b0, 1'b0});

    // Random ALU vectors against the integer model
    for (int i = 0; i < 64; i++) begin
      logic [2:0] s;
      logic [3:0] a, b;
      s = 3'($urandom_range(0, 7));
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      alu_apply($sformatf("alu_rand%0d_op%0d", i, s), s, a, b, alu_model(s, a, b));
    end

`ifdef ALU_OUT_REG_EN
    // One-cycle latency: old value before the edge, new value after it
    @(negedge clk);
    alu_fnselec = 3'b000; alu_a = 4'b0011; alu_b = 4'b0100;
    #1;
    check("reg_before_edge", 32'({alu_res, alu_zero, alu_overflow, alu_carry}),
          32'(last_alu_exp));
    @(posedge clk); #1;
    check("reg_after_edge", 32'({alu_res, alu_zero, alu_overflow, alu_carry}),
          32'({4'b0111, 1'b0, 1'b0, 1'b0}));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("reg_rst_clear", 32'({alu_res, alu_zero, alu_overflow, alu_carry}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
`endif

    // Counter: reset, nine decrements with wrap, hold, reset beating enable
    cnt_step("cnt_rst", 1'b1, 1'b0, 3'd0);
    for (int i = 0; i < 9; i++)
      cnt_step($sformatf("cnt_dec%0d", i), 1'b0, 1'b1, 3'(exp_cnt[i]));
    cnt_step("cnt_hold0", 1'b0, 1'b0, 3'd7);
    cnt_step("cnt_hold1", 1'b0, 1'b0, 3'd7);
    cnt_step("cnt_rst_en", 1'b1, 1'b1, 3'd0);
    cnt_step("cnt_wrap2", 1'b0, 1'b1, 3'd7);
    cnt_step("cnt_dec_more", 1'b0, 1'b1, 3'd6);
    @(negedge clk);
    cnt_en = 1'b0;

    // Decoder sweep and disable
    for (int i = 0; i < 8; i++) begin
      logic [7:0] e;
      e = 8'h00;
      e[i] = 1'b1;
      @(negedge clk);
      dec_en = 1'b1; dec_x = 3'(i);
      push_exp($sformatf("dec_x%0d", i), 32'(e));
      #1;
      pop_check(32'(dec_y));
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      dec_en = 1'b0; dec_x = 3'(i);
      push_exp($sformatf("dec_off%0d", i), 32'd0);
      #1;
      pop_check(32'(dec_y));
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_cnt_dec_unit.md
Name: alu_cnt_dec_unit

Overview:
Lab-board arithmetic/control cluster grouping three independent functions behind one clock:
- a 4-bit ALU with eight operations and status flags;
- a wrapping down-counter;
- a 3-to-8 one-hot decoder with enable.

It sits beside the board I/O glue. Switches drive the ALU and decoder; the counter advances on a slow tick-qualified enable and feeds LEDs/7-segment logic.

Parameters:
ALU_W, 4, ALU operand/result width (flag rules below are written for the MSB, bit ALU_W-1).
CNT_W, 3, down-counter width.

Ports:
clk  input  1  single system clock; all state on rising edge.
rst  input  1  reset, synchronous, active-high.
alu_fnselec  input  3  ALU operation select.
alu_a  input  ALU_W  operand A.
alu_b  input  ALU_W  operand B.
alu_res  output  ALU_W  ALU result.
alu_zero  output  1  high when alu_res is all zeros.
alu_overflow  output  1  signed overflow flag.
alu_carry  output  1  carry-out flag.
cnt_en  input  1  counter enable (one decrement per clk while high).
cnt_q  output  CNT_W  down-counter value.
cnt_tc  output  1  high while cnt_q == 0.
dec_en  input  1  decoder enable.
dec_x  input  3  decoder select.
dec_y  output  8  one-hot decoder output.

Behaviour:
- Reset: synchronous, active-high, on `rst`.
- ALU is combinational in the default build. Operation encoding by alu_fnselec:
  - 000 ADD: {carry,res} = a+b. overflow = (a[MSB]==b[MSB]) && (res[MSB]!=a[MSB]).
  - 001 SUB: res = a + ~b + 1. carry = carry-out of that sum (1 when a >= b unsigned). overflow = (a[MSB]!=b[MSB]) && (res[MSB]!=a[MSB]).
  - 010 NOT: res = ~a.
  - 011 AND: res = a & b.
  - 100 OR: res = a | b.
  - 101 XOR: res = a ^ b.
  - 110 LT (signed): res = {0…, less}, where less = sub_res[MSB] ^ sub_overflow.
  - 111 EQ: res = {0…, (a==b)}.
- Flags:
  - carry and overflow are 0 for every op except ADD/SUB.
  - zero = (res == 0) for every op.
  - No X on any output for any input combination.
- Counter:
  - rst → cnt_q = 0.
  - Else if cnt_en: cnt_q ← cnt_q − 1, wrapping 0 → 2^CNT_W−1 (7 by default).
  - Else hold.
  - rst wins over cnt_en in the same cycle.
  - cnt_tc = (cnt_q == 0), combinational from the register, so cnt_tc = 1 out of reset.
- Decoder: dec_y = dec_en ? (8'b1 << dec_x) : 8'b0. Combinational, no state.
- Unaffected by rst: ALU and decoder (default build).

Optional Feature:
Macro ALU_OUT_REG_EN.
- Defined: alu_res/alu_zero/alu_overflow/alu_carry are registered on clk, giving 1-cycle latency from operand/select change. rst clears all four to 0 (so alu_zero reads 0 during reset).
- Undefined: pure combinational, zero latency.
- Counter and decoder are identical in both builds.

Decomposition:
- Shared package alu_cnt_dec_pkg holds:
  - localparams for the eight op encodings (ALU_ADD…ALU_EQ);
  - default widths ALU_W = 4 and CNT_W = 3.
- One natural sub-module, alu_core: the combinational ALU including the flag logic. The top instantiates it and optionally adds the output register.
- Counter and decoder stay inline in the top.

Test Plan:
- ALU ADD overflow: a=0111, b=0001, sel=000 → res=1000, overflow=1, carry=0, zero=0. Then a=1111, b=0001 → res=0000, carry=1, zero=1, overflow=0.
- ALU SUB/LT:
  - a=1000, b=0001, sel=001 → res=0111, overflow=1, carry=1.
  - sel=110 with a=1000 (−8), b=0001 → res=0001.
  - a=0011, b=1111, sel=110 → res=0000, zero=1.
- ALU logic/EQ:
  - a=1010, b=0110: NOT → 0101; AND → 0010; OR → 1110; XOR → 1100.
  - EQ with a=b=0101 → 0001; carry=overflow=0 throughout.
- Counter wrap: rst 1 cycle → cnt_q=0, cnt_tc=1. Then cnt_en=1 for 9 cycles → 7,6,5,4,3,2,1,0,7. Deassert cnt_en → value holds. Assert rst together with cnt_en → 0 next edge.
- Decoder: dec_en=1 sweeping dec_x 0..7 → dec_y = 01,02,04,08,10,20,40,80 (hex). dec_en=0 with any dec_x → 00.
- ALU_OUT_REG_EN build: apply ADD 0011+0100 → alu_res=0111 exactly one clk later, with previous value before the edge. rst → all ALU outputs 0.
